store_path_unit: RTL and testbench

- Store-side counterpart of the writeback load-extraction logic.
- Takes committed stores from the memory stage and packs register data into the byte lanes selected by a 4-bit lane mask. Applies the same device/non-device byte ordering that loads undo.
- Buffers stores in a small FIFO and drains them to the data SRAM over a req/addr_ok/data_ok handshake.
- Tells the pipeline when to stall, and tells loads when the buffer is empty.

---
 rtl/store_path_unit_pkg.sv | 24 ++
 rtl/store_path_unit_sb_fifo.sv | 55 +++++
 rtl/store_path_unit.sv | 139 +++++++++++++
 tb/tb_store_path_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_path_unit_pkg.sv
// store_path_unit_pkg: lane masks, size encodings, reset level and FSM states
// shared by the store path.
package store_path_unit_pkg;
    localparam logic        RST_ENABLE     = 1'b0;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

    localparam logic [3:0]  WSEL_WORD      = 4'b1111;
    localparam logic [3:0]  WSEL_HI_HALF   = 4'b1100;
    localparam logic [3:0]  WSEL_LO_HALF   = 4'b0011;
    localparam logic [3:0]  WSEL_B3        = 4'b1000;
    localparam logic [3:0]  WSEL_B2        = 4'b0100;
    localparam logic [3:0]  WSEL_B1        = 4'b0010;
    localparam logic [3:0]  WSEL_B0        = 4'b0001;

    localparam logic [1:0]  DATA_SIZE_BYTE = 2'd0;
    localparam logic [1:0]  DATA_SIZE_HALF = 2'd1;
    localparam logic [1:0]  DATA_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_REQ  = 2'd1,
        SB_WAIT = 2'd2
    } sb_state_e;
endpackage

// File: rtl/store_path_unit_sb_fifo.sv
// sb_fifo: generic synchronous FIFO (power-of-two depth) with push/pop,
// full/empty flags and an occupancy count.
module sb_fifo
    import store_path_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & !full;
        do_pop   = pop & !empty;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst_n == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/store_path_unit.sv
// store_path_unit: packs committed stores into byte lanes, buffers them and
// drains them over an SRAM-like req/addr_ok/data_ok bus. SB_PERF_CNT_EN adds a stall counter.
module store_path_unit
    import store_path_unit_pkg::*;
#(
    parameter int SB_DEPTH = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [3:0]        st_wsel_i,
    input  logic [31:0]       st_din_i,
    input  logic              st_device_i,
    output logic              sb_empty_o,
    output logic              sb_err_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
`ifdef SB_PERF_CNT_EN
    ,
    output logic [31:0]       sb_stall_cnt_o
`endif
);
    localparam int EW = ADDR_W + 4 + 32 + 2;
    localparam int CW = $clog2(SB_DEPTH) + 1;

    sb_state_e         state_q, state_d;
    logic              err_q, err_d;
    logic              legal, push, pop, full, empty;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;

    // Non-device stores are byte-swapped so loads can undo the same ordering
    always_comb begin
        legal = 1'b1;
        wdata = ZERO_WORD;
        size  = DATA_SIZE_BYTE;
        case (st_wsel_i)
            WSEL_WORD: begin
                wdata = st_device_i ? st_din_i
                      : {st_din_i[7:0], st_din_i[15:8], st_din_i[23:16], st_din_i[31:24]};
                size  = DATA_SIZE_WORD;
            end
            WSEL_HI_HALF: begin
                wdata = {st_din_i[7:0], st_din_i[15:8], 16'h0};
                size  = DATA_SIZE_HALF;
            end
            WSEL_LO_HALF: begin
                wdata = {16'h0, st_din_i[7:0], st_din_i[15:8]};
                size  = DATA_SIZE_HALF;
            end
            WSEL_B3: wdata = {st_din_i[7:0], 24'h0};
            WSEL_B2: wdata = {8'h0, st_din_i[7:0], 16'h0};
            WSEL_B1: wdata = {16'h0, st_din_i[7:0], 8'h0};
            WSEL_B0: wdata = {24'h0, st_din_i[7:0]};
            default: legal = 1'b0;
        endcase
        push  = st_valid_i & st_ready_o & legal;
        err_d = st_valid_i & st_ready_o & !legal;
    end

    sb_fifo #(.DEPTH(SB_DEPTH), .WIDTH(EW)) u_fifo (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({st_addr_i, st_wsel_i, wdata, size}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            SB_IDLE: if (!empty) state_d = SB_REQ;
            SB_REQ: begin
                if (data_addr_ok) begin
                    pop     = data_data_ok;
                    state_d = !data_data_ok ? SB_WAIT : (count > CW'(1)) ? SB_REQ : SB_IDLE;
                end
            end
            SB_WAIT: begin
                if (data_data_ok) begin
                    pop     = 1'b1;
                    state_d = (count > CW'(1)) ? SB_REQ : SB_IDLE;
                end
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state_q <= SB_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign st_ready_o = !full;
    assign sb_empty_o = empty & (state_q == SB_IDLE);
    assign sb_err_o   = err_q;
    assign data_req   = state_q == SB_REQ;
    assign data_wr    = data_req;
    assign data_addr  = data_req ? head[EW-1 -: ADDR_W] : '0;
    assign data_wstrb = data_req ? head[37:34] : 4'h0;
    assign data_wdata = data_req ? head[33:2] : ZERO_WORD;
    assign data_size  = data_req ? head[1:0] : DATA_SIZE_BYTE;

`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = (st_valid_i & !st_ready_o & (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n == RST_ENABLE) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end

    assign sb_stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_store_path_unit.sv
// tb_store_path_unit: directed stimulus with literal expectations plus a
// queue-based model of the store buffer checked every cycle.
module tb_store_path_unit;
    localparam int DEPTH = 2;

    logic        cpu_clk_50M, cpu_rst_n;
    logic        st_valid_i, st_ready_o, st_device_i;
    logic [31:0] st_addr_i, st_din_i;
    logic [3:0]  st_wsel_i;
    logic        sb_empty_o, sb_err_o, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
`ifdef SB_PERF_CNT_EN
    logic [31:0] sb_stall_cnt_o;
`endif

    store_path_unit #(.SB_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst_n    (cpu_rst_n),
        .st_valid_i   (st_valid_i),
        .st_ready_o   (st_ready_o),
        .st_addr_i    (st_addr_i),
        .st_wsel_i    (st_wsel_i),
        .st_din_i     (st_din_i),
        .st_device_i  (st_device_i),
        .sb_empty_o   (sb_empty_o),
        .sb_err_o     (sb_err_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
`ifdef SB_PERF_CNT_EN
        ,
        .sb_stall_cnt_o (sb_stall_cnt_o)
`endif
    );

    initial cpu_clk_50M = 1'b0;
    always #5 cpu_clk_50M = ~cpu_clk_50M;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: stores are bytes d[7:0], d[15:8], ... placed into the selected
    // lanes from the highest lane down; a device word keeps its order.
    function automatic logic [31:0] m_pack(input logic [3:0] m, input logic [31:0] d, input logic dev);
        logic [31:0] r;
        int k;
        r = 32'h0;
        k = 0;
        if (m == 4'hF && dev) return d;
        for (int l = 3; l >= 0; l--) begin
            if (m[l]) begin
                r[l*8 +: 8] = d[k*8 +: 8];
                k++;
            end
        end
        return r;
    endfunction

    function automatic bit m_legal(input logic [3:0] m);
        return m inside {4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
    endfunction

    function automatic logic [1:0] m_size(input logic [3:0] m);
        return ($countones(m) == 1) ? 2'd0 : ($countones(m) == 2) ? 2'd1 : 2'd2;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [1:0]  size;
    } ent_t;

    ent_t        mq[$];
    bit          inflight = 0;
    bit          m_err = 0;
    logic [31:0] seen[$];

    always @(negedge cpu_clk_50M) begin
        if (chk_en) begin
            bit acc, do_pop;
            ent_t e;
            chk("m_ready", st_ready_o, mq.size() < DEPTH);
            chk("m_empty", sb_empty_o, mq.size() == 0);
            chk("m_err", sb_err_o, m_err);
            chk("m_wr", data_wr, data_req);
            if (data_req) begin
                chk("m_req_allowed", {inflight, mq.size() == 0}, 0);
                if (mq.size() > 0) begin
                    chk("m_addr", data_addr, mq[0].addr);
                    chk("m_wstrb", data_wstrb, mq[0].wstrb);
                    chk("m_wdata", data_wdata, mq[0].wdata);
                    chk("m_size", data_size, mq[0].size);
                end
            end
            if (!cpu_rst_n) begin
                mq.delete();
                inflight = 0;
                m_err = 0;
            end else begin
                if (data_req && data_addr_ok) seen.push_back(data_addr);
                acc = st_valid_i && (mq.size() < DEPTH);
                do_pop = 0;
                if (data_req && data_addr_ok) begin
                    if (data_data_ok) do_pop = 1;
                    else inflight = 1;
                end else if (inflight && data_data_ok) begin
                    do_pop = 1;
                    inflight = 0;
                end
                if (do_pop && mq.size() > 0) void'(mq.pop_front());
                m_err = acc && !m_legal(st_wsel_i);
                if (acc && m_legal(st_wsel_i)) begin
                    e.addr  = st_addr_i;
                    e.wstrb = st_wsel_i;
                    e.wdata = m_pack(st_wsel_i, st_din_i, st_device_i);
                    e.size  = m_size(st_wsel_i);
                    mq.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input logic dev);
        st_valid_i  = 1'b1;
        st_addr_i   = a;
        st_wsel_i   = m;
        st_din_i    = d;
        st_device_i = dev;
        tick();
        st_valid_i = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        for (int i = 0; i < 20 && !data_req; i++) tick();
        chk(nm, data_req, 1'b1);
    endtask

    task automatic ack_both();
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    task automatic ack_split();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit accepted;
        cpu_rst_n = 1'b0;
        st_valid_i = 1'b0; st_addr_i = '0; st_wsel_i = '0; st_din_i = '0; st_device_i = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick();
        tick();
        chk("rst_req", data_req, 1'b0);
        chk("rst_wr", data_wr, 1'b0);
        chk("rst_ready", st_ready_o, 1'b1);
        chk("rst_empty", sb_empty_o, 1'b1);
        chk("rst_err", sb_err_o, 1'b0);
        chk("rst_outs", {data_size, data_addr, data_wstrb, data_wdata}, 0);
        chk("pin_model_word", m_pack(4'hF, 32'h11223344, 1'b0), 32'h44332211);
        chk("pin_model_hi", m_pack(4'hC, 32'h0000BEEF, 1'b0), 32'hEFBE0000);
        cpu_rst_n = 1'b1;
        chk_en = 1;

        // Word, non-device, with two-cycle request latency
        send(32'h100, 4'hF, 32'h11223344, 1'b0);
        chk("w_req_lat1", data_req, 1'b0);
        chk("w_notempty", sb_empty_o, 1'b0);
        tick();
        chk("w_req_lat2", data_req, 1'b1);
        chk("w_wdata", data_wdata, 32'h44332211);
        chk("w_size", data_size, 2'd2);
        chk("w_wstrb", data_wstrb, 4'hF);
        chk("w_addr", data_addr, 32'h100);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("w_wait_noreq", data_req, 1'b0);
        chk("w_wait_notempty", sb_empty_o, 1'b0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("w_empty", sb_empty_o, 1'b1);

        // Byte lane 2, addr_ok and data_ok together
        send(32'h104, 4'b0100, 32'hAABBCCDD, 1'b0);
        wait_req("b_req");
        chk("b_wdata", data_wdata, 32'h00DD0000);
        chk("b_size", data_size, 2'd0);
        ack_both();
        chk("b_empty", sb_empty_o, 1'b1);

        // Low half
        send(32'h108, 4'b0011, 32'h0000BEEF, 1'b0);
        wait_req("h_req");
        chk("h_wdata", data_wdata, 32'h0000EFBE);
        chk("h_size", data_size, 2'd1);
        ack_split();
        chk("h_empty", sb_empty_o, 1'b1);

        // Device word keeps order
        send(32'h10C, 4'hF, 32'hCAFEF00D, 1'b1);
        wait_req("d_req");
        chk("d_wdata", data_wdata, 32'hCAFEF00D);
        ack_split();

        // Backpressure: three stores with addr_ok held low
        seen.delete();
        send(32'h200, 4'hF, 32'h01020304, 1'b1);
        send(32'h204, 4'b1000, 32'h000000AB, 1'b0);
        st_valid_i = 1'b1; st_addr_i = 32'h208; st_wsel_i = 4'b0001; st_din_i = 32'h000000CD; st_device_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", st_ready_o, 1'b0);
            chk("bp_addr_stable", data_addr, 32'h200);
            chk("bp_req", data_req, 1'b1);
            tick();
        end
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        accepted = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = st_ready_o;
            tick();
        end
        chk("bp_accepted", accepted, 1'b1);
        st_valid_i = 1'b0;
        for (int i = 0; i < 20 && !sb_empty_o; i++) tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("bp_drained", sb_empty_o, 1'b1);
        chk("bp_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("bp_order0", seen[0], 32'h200);
            chk("bp_order1", seen[1], 32'h204);
            chk("bp_order2", seen[2], 32'h208);
        end

        // Illegal masks are dropped with a single-cycle error pulse
        send(32'h300, 4'b0101, 32'h12345678, 1'b0);
        chk("il_err_hi", sb_err_o, 1'b1);
        chk("il_noreq", data_req, 1'b0);
        tick();
        chk("il_err_lo", sb_err_o, 1'b0);
        tick();
        chk("il_noreq2", data_req, 1'b0);
        chk("il_empty", sb_empty_o, 1'b1);
        send(32'h300, 4'b0000, 32'h12345678, 1'b0);
        chk("il0_err", sb_err_o, 1'b1);

        // Reset while waiting on data_ok with two entries buffered
        send(32'h400, 4'hF, 32'hA1A2A3A4, 1'b0);
        send(32'h404, 4'hF, 32'hB1B2B3B4, 1'b0);
        wait_req("r_req");
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("r_in_wait", data_req, 1'b0);
        cpu_rst_n = 1'b0;
        tick();
        cpu_rst_n = 1'b1;
        chk("r_req_clr", data_req, 1'b0);
        chk("r_empty", sb_empty_o, 1'b1);
        chk("r_ready", st_ready_o, 1'b1);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("r_late_ok_empty", sb_empty_o, 1'b1);
        tick();
        tick();
        chk("r_late_ok_noreq", data_req, 1'b0);
        chk("r_late_ok_ready", st_ready_o, 1'b1);

        send(32'h500, 4'b0001, 32'h12345678, 1'b0);
        wait_req("post_req");
        chk("post_wdata", data_wdata, 32'h00000078);
        chk("post_addr", data_addr, 32'h500);
        ack_both();
        chk("post_empty", sb_empty_o, 1'b1);

        tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
